// File: rtl/dmem_sched.sv
// Data-memory port scheduler: serialises dual-slot memory ops onto one BRAM port and tags returning loads.
// Optional statistics counters (conflict_cnt, ld_cnt) are enabled with `define DMEM_SCHED_STATS_EN.
module dmem_sched #(
   parameter int ADDR_W  = 16,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              flush,
   input  logic              u_req,
   input  logic              l_req,
   input  logic              u_we,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] u_addr,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [31:0]       u_wdata,
   input  logic [31:0]       l_wdata,
   input  logic [4:0]        u_rt,
   input  logic [4:0]        l_rt,
   output logic              stall,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              ld_valid,
   output logic              ld_slot,
   output logic [4:0]        ld_rt,
`ifdef DMEM_SCHED_STATS_EN
   output logic [31:0]       conflict_cnt,
   output logic [31:0]       ld_cnt,
`endif
   output logic [31:0]       ld_data
);

   typedef enum logic {IDLE, SECOND} state_t;

   state_t            state;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [31:0]       lat_wdata;
   logic [4:0]        lat_rt;

   logic              issue;
   logic              issue_slot;
   logic [4:0]        issue_rt;
   logic              load_issue;

   // Each entry is {valid, slot, rt}; the tail lines up with mem_rdata.
   logic [6:0]        pipe [MEM_LAT];

   // Outputs are gated by rst so they drop to reset values the moment reset rises.
   always_comb begin
      stall      = 1'b0;
      issue      = 1'b0;
      issue_slot = 1'b0;
      issue_rt   = '0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      if (!rst) begin
         if (state == SECOND) begin
            if (!flush) begin
               issue      = 1'b1;
               issue_slot = 1'b1;
               issue_rt   = lat_rt;
               mem_we     = lat_we;
               mem_addr   = lat_addr;
               mem_wdata  = lat_wdata;
            end
         end else if (in_valid) begin
            stall = u_req & l_req;
            if (u_req) begin
               issue     = 1'b1;
               issue_rt  = u_rt;
               mem_we    = u_we;
               mem_addr  = u_addr;
               mem_wdata = u_wdata;
            end else if (l_req) begin
               issue      = 1'b1;
               issue_slot = 1'b1;
               issue_rt   = l_rt;
               mem_we     = l_we;
               mem_addr   = l_addr;
               mem_wdata  = l_wdata;
            end
         end
      end
   end

   assign mem_en     = issue;
   assign load_issue = issue & ~mem_we;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_rt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (stall) begin
                  lat_we    <= l_we;
                  lat_addr  <= l_addr;
                  lat_wdata <= l_wdata;
                  lat_rt    <= l_rt;
                  state     <= SECOND;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MEM_LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= load_issue ? {1'b1, issue_slot, issue_rt} : 7'd0;
         for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign {ld_valid, ld_slot, ld_rt} = pipe[MEM_LAT-1];
   assign ld_data = mem_rdata;

`ifdef DMEM_SCHED_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_cnt <= '0;
         ld_cnt       <= '0;
      end else begin
         if (stall)      conflict_cnt <= conflict_cnt + 32'd1;
         if (load_issue) ld_cnt       <= ld_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_sched.sv
// Self-checking bench for dmem_sched: transaction-level expectation tables plus a small BRAM model.
// Stats checks compile in only when DMEM_SCHED_STATS_EN is defined.
module tb_dmem_sched;

   localparam int LAT = 2;
   localparam int DEPTH = 512;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0, flush = 1'b0;
   logic        u_req = 1'b0, l_req = 1'b0, u_we = 1'b0, l_we = 1'b0;
   logic [15:0] u_addr = '0, l_addr = '0;
   logic [31:0] u_wdata = '0, l_wdata = '0;
   logic [4:0]  u_rt = '0, l_rt = '0;
   logic        stall, mem_en, mem_we, ld_valid, ld_slot;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata, ld_data;
   logic [4:0]  ld_rt;
`ifdef DMEM_SCHED_STATS_EN
   logic [31:0] conflict_cnt, ld_cnt;
`endif

   dmem_sched #(.ADDR_W(16), .MEM_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
      .u_req(u_req), .l_req(l_req), .u_we(u_we), .l_we(l_we),
      .u_addr(u_addr), .l_addr(l_addr), .u_wdata(u_wdata), .l_wdata(l_wdata),
      .u_rt(u_rt), .l_rt(l_rt), .stall(stall), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .ld_valid(ld_valid), .ld_slot(ld_slot), .ld_rt(ld_rt),
`ifdef DMEM_SCHED_STATS_EN
      .conflict_cnt(conflict_cnt), .ld_cnt(ld_cnt),
`endif
      .ld_data(ld_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_val(int a);
      if (a == 16'h0010) return 32'hDEADBEEF;
      return {a[15:0] ^ 16'hA5A5, a[15:0]};
   endfunction

   // BRAM with two-cycle read latency; unwritten words read their init pattern.
   logic [31:0]     bram [1024];
   logic [1023:0]   written = '0;
   logic [31:0]     rd1;
   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         bram[mem_addr[9:0]]    <= mem_wdata;
         written[mem_addr[9:0]] <= 1'b1;
      end
      rd1       <= written[mem_addr[9:0]] ? bram[mem_addr[9:0]] : init_val(int'(mem_addr[9:0]));
      mem_rdata <= rd1;
   end

   // Expectations indexed by cycle, filled in program order by the driver.
   logic [31:0] ref_mem [1024];
   logic        exp_stall [DEPTH], exp_en [DEPTH], exp_we [DEPTH], exp_ldv [DEPTH], exp_slot [DEPTH];
   logic [15:0] exp_addr [DEPTH];
   logic [31:0] exp_wdata [DEPTH], exp_data [DEPTH];
   logic [4:0]  exp_rt [DEPTH];
   logic [31:0] act_stall [DEPTH], act_en [DEPTH], act_we [DEPTH], act_addr [DEPTH];
   logic [31:0] act_ldv [DEPTH], act_slot [DEPTH], act_rt [DEPTH], act_data [DEPTH];

   int n_checks = 0;
   int n_fail = 0;
   logic chk_en = 1'b0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_expect(input int from);
      for (int i = from; i < DEPTH; i++) begin
         exp_stall[i] = 0; exp_en[i] = 0; exp_we[i] = 0; exp_ldv[i] = 0; exp_slot[i] = 0;
         exp_addr[i] = '0; exp_wdata[i] = '0; exp_data[i] = '0; exp_rt[i] = '0;
      end
   endtask

   task automatic expect_access(input int t, input logic slot, input logic we,
                                input logic [15:0] a, input logic [31:0] d, input logic [4:0] rt);
      exp_en[t] = 1; exp_we[t] = we; exp_addr[t] = a; exp_wdata[t] = d;
      if (we) ref_mem[a[9:0]] = d;
      else begin
         exp_ldv[t+LAT] = 1; exp_slot[t+LAT] = slot; exp_rt[t+LAT] = rt;
         exp_data[t+LAT] = ref_mem[a[9:0]];
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Drives one bundle; a two-op bundle is held for its second cycle, with optional flush there.
   task automatic apply_stimulus(input logic v,
         input logic ur, input logic uw, input logic [15:0] ua, input logic [31:0] ud, input logic [4:0] urt,
         input logic lr, input logic lw, input logic [15:0] la, input logic [31:0] ld, input logic [4:0] lrt,
         input logic fl_idle, input logic fl_second);
      int c;
      c = cyc;
      in_valid = v; u_req = ur; u_we = uw; u_addr = ua; u_wdata = ud; u_rt = urt;
      l_req = lr; l_we = lw; l_addr = la; l_wdata = ld; l_rt = lrt; flush = fl_idle;
      if (v && ur && lr) begin
         exp_stall[c] = 1;
         expect_access(c, 0, uw, ua, ud, urt);
         if (!fl_second) expect_access(c + 1, 1, lw, la, ld, lrt);
         @(posedge clk); #1;
         flush = fl_second;
      end else if (v && ur) expect_access(c, 0, uw, ua, ud, urt);
      else if (v && lr) expect_access(c, 1, lw, la, ld, lrt);
      @(posedge clk); #1;
      in_valid = 0; u_req = 0; l_req = 0; u_we = 0; l_we = 0; flush = 0;
   endtask

   // Logs every cycle and compares against the expectation tables while enabled.
   always @(negedge clk) begin
      act_stall[cyc] = 32'(stall); act_en[cyc] = 32'(mem_en); act_we[cyc] = 32'(mem_we);
      act_addr[cyc] = 32'(mem_addr); act_ldv[cyc] = 32'(ld_valid); act_slot[cyc] = 32'(ld_slot);
      act_rt[cyc] = 32'(ld_rt); act_data[cyc] = ld_data;
      if (chk_en) begin
         check_output("stall", 32'(stall), 32'(exp_stall[cyc]));
         check_output("mem_en", 32'(mem_en), 32'(exp_en[cyc]));
         if (exp_en[cyc]) begin
            check_output("mem_we", 32'(mem_we), 32'(exp_we[cyc]));
            check_output("mem_addr", 32'(mem_addr), 32'(exp_addr[cyc]));
            if (exp_we[cyc]) check_output("mem_wdata", mem_wdata, exp_wdata[cyc]);
         end
         check_output("ld_valid", 32'(ld_valid), 32'(exp_ldv[cyc]));
         if (exp_ldv[cyc]) begin
            check_output("ld_slot", 32'(ld_slot), 32'(exp_slot[cyc]));
            check_output("ld_rt", 32'(ld_rt), 32'(exp_rt[cyc]));
            check_output("ld_data", ld_data, exp_data[cyc]);
         end
      end
   end

   int n;

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
      clear_expect(0);

      #1 rst = 1'b1;
      #1;
      check_output("rst_stall", 32'(stall), 0);
      check_output("rst_mem_en", 32'(mem_en), 0);
      check_output("rst_mem_we", 32'(mem_we), 0);
      check_output("rst_mem_addr", 32'(mem_addr), 0);
      check_output("rst_mem_wdata", mem_wdata, 0);
      check_output("rst_ld_valid", 32'(ld_valid), 0);
      check_output("rst_ld_slot", 32'(ld_slot), 0);
      check_output("rst_ld_rt", 32'(ld_rt), 0);
`ifdef DMEM_SCHED_STATS_EN
      check_output("rst_conflict_cnt", conflict_cnt, 0);
      check_output("rst_ld_cnt", ld_cnt, 0);
`endif
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      chk_en = 1'b1;
      idle(1);

      // Single upper load
      n = cyc;
      apply_stimulus(1, 1, 0, 16'h0010, 0, 5, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      check_output("t1_en", act_en[n], 1);
      check_output("t1_stall", act_stall[n], 0);
      check_output("t1_ldv", act_ldv[n+2], 1);
      check_output("t1_slot", act_slot[n+2], 0);
      check_output("t1_rt", act_rt[n+2], 5);
      check_output("t1_data", act_data[n+2], 32'hDEADBEEF);

      // Upper store then lower load of the same word
      n = cyc;
      apply_stimulus(1, 1, 1, 16'h0020, 32'h12345678, 0, 1, 0, 16'h0020, 0, 9, 0, 0);
      idle(4);
      check_output("t2_stall0", act_stall[n], 1);
      check_output("t2_we0", act_we[n], 1);
      check_output("t2_addr0", act_addr[n], 32'h20);
      check_output("t2_stall1", act_stall[n+1], 0);
      check_output("t2_ldv", act_ldv[n+3], 1);
      check_output("t2_slot", act_slot[n+3], 1);
      check_output("t2_rt", act_rt[n+3], 9);
      check_output("t2_data", act_data[n+3], 32'h12345678);

      // Dual load returns on consecutive cycles
      n = cyc;
      apply_stimulus(1, 1, 0, 16'h0010, 0, 3, 1, 0, 16'h0011, 0, 4, 0, 0);
      idle(4);
      check_output("t3_up_rt", act_rt[n+2], 3);
      check_output("t3_up_slot", act_slot[n+2], 0);
      check_output("t3_lo_rt", act_rt[n+3], 4);
      check_output("t3_lo_slot", act_slot[n+3], 1);

      // Back-to-back conflicting bundles
      n = cyc;
      apply_stimulus(1, 1, 1, 16'h0040, 32'hA0A0A0A0, 0, 1, 0, 16'h0041, 0, 12, 0, 0);
      apply_stimulus(1, 1, 0, 16'h0040, 0, 13, 1, 1, 16'h0041, 32'hB1B1B1B1, 0, 0, 0);
      idle(4);
      check_output("t4_stall0", act_stall[n], 1);
      check_output("t4_stall1", act_stall[n+1], 0);
      check_output("t4_stall2", act_stall[n+2], 1);
      check_output("t4_stall3", act_stall[n+3], 0);
      check_output("t4_addr3", act_addr[n+3], 32'h41);

      // Flush during the second cycle drops the latched lower store
      n = cyc;
      apply_stimulus(1, 1, 0, 16'h0012, 0, 6, 1, 1, 16'h0013, 32'hCAFEF00D, 0, 0, 1);
      idle(3);
      check_output("t5_en1", act_en[n+1], 0);
      check_output("t5_ldv", act_ldv[n+2], 1);
      check_output("t5_rt", act_rt[n+2], 6);

      // Flush in IDLE does not block a lower-only load; it also shows 0x13 was never written
      apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0, 16'h0013, 0, 11, 1, 0);
      // Bundle not valid: no access even with requests raised
      apply_stimulus(0, 1, 1, 16'h0050, 32'h55555555, 0, 1, 1, 16'h0051, 32'h66666666, 0, 0, 0);
      apply_stimulus(1, 0, 0, 0, 0, 0, 1, 1, 16'h0060, 32'h01020304, 0, 0, 0);
      apply_stimulus(1, 1, 1, 16'h0061, 32'h0A0B0C0D, 0, 0, 0, 0, 0, 0, 0, 0);
      apply_stimulus(1, 1, 0, 16'h0060, 0, 20, 1, 0, 16'h0061, 0, 21, 0, 0);
      idle(4);

      // Asynchronous reset in the second cycle of a dual load
      chk_en = 1'b0;
      in_valid = 1; u_req = 1; u_we = 0; u_addr = 16'h0030; u_rt = 7;
      l_req = 1; l_we = 0; l_addr = 16'h0031; l_rt = 8;
      @(posedge clk); #1;
      #1;
      check_output("t6_pre_en", 32'(mem_en), 1);
      check_output("t6_pre_addr", 32'(mem_addr), 32'h31);
      #1 rst = 1'b1;
      #1;
      check_output("t6_stall", 32'(stall), 0);
      check_output("t6_mem_en", 32'(mem_en), 0);
      check_output("t6_mem_we", 32'(mem_we), 0);
      check_output("t6_mem_addr", 32'(mem_addr), 0);
      check_output("t6_mem_wdata", mem_wdata, 0);
      check_output("t6_ld_valid", 32'(ld_valid), 0);
      check_output("t6_ld_slot", 32'(ld_slot), 0);
      check_output("t6_ld_rt", 32'(ld_rt), 0);
      in_valid = 0; u_req = 0; l_req = 0;
      @(posedge clk); #1;
      rst = 1'b0;
`ifdef DMEM_SCHED_STATS_EN
      check_output("t6_conflict_cnt", conflict_cnt, 0);
`endif
      for (int i = 0; i < 5; i++) begin
         #2 check_output("t6_no_ldv", 32'(ld_valid), 0);
         @(posedge clk); #1;
      end
      clear_expect(cyc);
      chk_en = 1'b1;

      // Normal operation resumes after reset
      n = cyc;
      apply_stimulus(1, 1, 0, 16'h0020, 0, 17, 1, 0, 16'h0010, 0, 18, 0, 0);
      idle(4);
      check_output("t7_up_data", act_data[n+2], 32'h12345678);
      check_output("t7_lo_data", act_data[n+3], 32'hDEADBEEF);
`ifdef DMEM_SCHED_STATS_EN
      check_output("t7_conflict_cnt", conflict_cnt, 1);
      check_output("t7_ld_cnt", ld_cnt, 2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_sched.md
# dmem_sched

Data-memory port scheduler for the dual-issue (upper/lower slot) pipeline. It shares the single data-memory BRAM port between the two slots of an exec-stage bundle. When both slots carry a memory op, it serialises them in program order (upper first) and raises a stall that freezes fetch/decode/exec for one cycle. It also tracks in-flight loads through the memory1/memory2 latency and tags each returning word with its slot and destination register for writeback.

## Interface
Parameters:
- ADDR_W, 16, word-address width of the data BRAM
- MEM_LAT, 2, BRAM read latency in cycles (request to rdata), legal range 1..4

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  exec-stage bundle valid
- flush  in  1  discard any latched second op
- u_req / l_req  in  1 each  slot carries a memory op
- u_we / l_we  in  1 each  1 = store, 0 = load
- u_addr / l_addr  in  ADDR_W each  word address
- u_wdata / l_wdata  in  32 each  store data
- u_rt / l_rt  in  5 each  load destination register
- stall  out  1  hold fetch/decode/exec this cycle
- mem_en  out  1  BRAM enable
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_W  BRAM address
- mem_wdata  out  32  BRAM write data
- mem_rdata  in  32  BRAM read data, valid MEM_LAT cycles after a load request
- ld_valid  out  1  load result valid
- ld_slot  out  1  0 = upper, 1 = lower
- ld_rt  out  5  destination register
- ld_data  out  32  load data (mem_rdata, passed through combinationally)

## Operation
- FSM states: IDLE, SECOND. Reset state is IDLE.
- IDLE:
  - in_valid with exactly one of u_req/l_req: issue that op this cycle. stall=0.
  - in_valid with both u_req and l_req: issue the upper op, latch the lower op (we, addr, wdata, rt), stall=1, next state SECOND.
  - in_valid=0 or no req: mem_en=0.
- SECOND:
  - Issue the latched lower op. stall=0. Next state IDLE.
  - All inputs are ignored; the bundle that upstream held is accepted this cycle.
- A bundle is accepted in any cycle with stall=0.
- flush in SECOND: the latched op is not issued, mem_en=0, next state IDLE. flush in IDLE has no effect on the current issue.
- Load tracking:
  - MEM_LAT-deep shift pipe carrying {valid, slot, rt}.
  - An entry enters on each issued load; ld_valid/ld_slot/ld_rt are the pipe tail.
  - Stores do not enter the pipe.
  - flush does not kill loads already in the pipe.
- Write-then-read ordering: an upper store followed by a lower load to the same address returns the new data, because the accesses are serialised.

## Timing
- Reset values: stall=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, ld_valid=0, ld_slot=0, ld_rt=0; load pipe cleared; FSM in IDLE.
- mem_* outputs are combinational from the FSM state and the inputs/latch, so a request is issued in the same cycle as the bundle.
- stall is combinational: stall = (state==IDLE) & in_valid & u_req & l_req.
- Load issued in cycle N: ld_valid=1 in cycle N+MEM_LAT, together with mem_rdata.
- Dual-load bundle: the upper result appears at N+MEM_LAT and the lower at N+MEM_LAT+1, on back-to-back cycles.
- Throughput:
  - one bundle per cycle without a conflict;
  - a conflicting bundle takes 2 cycles;
  - back-to-back conflicting bundles give the stall pattern 1,0,1,0.
- Asynchronous reset mid-SECOND: the latched op is dropped, the pipe is cleared, and the outputs go to their reset values immediately.

## Configuration
- DMEM_SCHED_STATS_EN defined:
  - adds output conflict_cnt [31:0], incremented in every cycle where stall=1;
  - adds output ld_cnt [31:0], incremented per issued load;
  - both reset to 0 and wrap at 2^32.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

## Test plan
- Single load: u_req=1, u_we=0, u_addr=0x0010, BRAM[0x10]=0xDEADBEEF, u_rt=5 -> mem_en=1 same cycle, stall=0; at N+2: ld_valid=1, ld_slot=0, ld_rt=5, ld_data=0xDEADBEEF.
- Dual op, upper store to 0x20 of 0x12345678, lower load from 0x20 (l_rt=9) -> cycle N: stall=1, mem_we=1, addr 0x20; N+1: stall=0, load issued; N+3: ld_valid, ld_slot=1, ld_rt=9, data 0x12345678.
- Dual load (rt 3, rt 4) -> returns on consecutive cycles N+2 (slot 0, rt 3) and N+3 (slot 1, rt 4).
- Two conflicting bundles back-to-back -> stall sequence 1,0,1,0 and four BRAM accesses in program order.
- flush asserted in SECOND -> mem_en=0 that cycle, no lower access, upper load still returns at N+2.
- rst pulse during SECOND with a load in flight -> all outputs 0 immediately, no ld_valid afterwards; with DMEM_SCHED_STATS_EN: conflict_cnt=0 after reset, =1 after one conflict.
